// File: rtl/gtp_drp_pkg.sv
// Shared types and helpers for the GTPE2 DRP read-modify-write sequencer.
package gtp_drp_pkg;

   localparam int DRP_ADDR_W_GTPE2 = 9;

   // The merge helper is written at a fixed width. Callers zero-extend into it
   // and truncate the result back to their DRP data width.
   localparam int DRP_MERGE_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_ISSUE,
      ST_WR_WAIT,
      ST_RESP
   } drp_state_e;

   // Bits set in mask come from wdata. All other bits keep the value read back.
   function automatic logic [DRP_MERGE_W-1:0] rmw_merge(
      input logic [DRP_MERGE_W-1:0] rd,
      input logic [DRP_MERGE_W-1:0] wdata,
      input logic [DRP_MERGE_W-1:0] mask
   );
      return (rd & ~mask) | (wdata & mask);
   endfunction

endpackage

// File: rtl/gtp_drp_timeout_cnt.sv
// DRPRDY wait counter: cleared on load, counts while enabled, flags the last
// allowed wait cycle.
module gtp_drp_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear on issue, count each wait cycle, hold at the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/gtp_drp_rmw_sequencer.sv
// DRP master for N GTPE2 slaves: plain reads and masked read-modify-writes,
// with DRPRDY timeout and a saturating error counter.
//
//  state        | meaning
//  -------------+-----------------------------------------------------
//  ST_IDLE      | ready for a request
//  ST_RD_ISSUE  | DRPEN pulse for the read
//  ST_RD_WAIT   | waiting for DRPRDY. The read data is captured on the rdy cycle.
//  ST_WR_ISSUE  | DRPEN+DRPWE pulse carrying the merged data
//  ST_WR_WAIT   | waiting for DRPRDY of the write
//  ST_RESP      | response held until rsp_ready
module gtp_drp_rmw_sequencer
   import gtp_drp_pkg::*;
#(
   parameter int  N_CHANNELS     = 4,
   parameter int  ADDR_W         = DRP_ADDR_W_GTPE2,
   parameter int  DATA_W         = 16,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int CH_W           = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [CH_W-1:0]              req_ch,
   input  logic                         req_write,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   input  logic [DATA_W-1:0]            req_mask,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         busy,
   output logic [7:0]                   err_count,
   output logic [N_CHANNELS-1:0]        drp_en,
   output logic [N_CHANNELS-1:0]        drp_we,
   output logic [ADDR_W-1:0]            drp_addr,
   output logic [DATA_W-1:0]            drp_di,
   input  logic [N_CHANNELS*DATA_W-1:0] drp_do,
   input  logic [N_CHANNELS-1:0]        drp_rdy
);

   drp_state_e            state_q, state_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic                  write_q, write_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W-1:0]     mask_q, mask_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   logic [N_CHANNELS-1:0] ch_sel;
   logic                  rdy_sel;
   logic [DATA_W-1:0]     do_sel;
   logic                  in_issue, in_wait, to_expired;

   // Decode the latched channel and pick out its DRPRDY and DRPDO.
   always_comb begin
      ch_sel  = '0;
      rdy_sel = 1'b0;
      do_sel  = '0;
      for (int k = 0; k < N_CHANNELS; k++) begin
         if (ch_q == CH_W'(k)) begin
            ch_sel[k] = 1'b1;
            rdy_sel   = drp_rdy[k];
            do_sel    = drp_do[k*DATA_W +: DATA_W];
         end
      end
   end

   assign in_issue = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);
   assign in_wait  = (state_q == ST_RD_WAIT)  || (state_q == ST_WR_WAIT);

   gtp_drp_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (in_issue),
      .en      (in_wait),
      .expired (to_expired)
   );

   // Next-state and datapath. In a wait state, DRPRDY on the timeout boundary
   // counts as success.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      data_d    = data_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               ch_d    = req_ch;
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               mask_d  = req_mask;
               err_d   = 1'b0;
               data_d  = '0;
               if (int'(req_ch) >= N_CHANNELS) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_write && (&req_mask)) begin
                  data_d  = req_wdata;
                  state_d = ST_WR_ISSUE;
               end else begin
                  state_d = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_WR_ISSUE: state_d = ST_WR_WAIT;
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (rdy_sel) begin
               if (state_q == ST_WR_WAIT) begin
                  state_d = ST_RESP;
               end else if (write_q) begin
                  data_d  = DATA_W'(rmw_merge(DRP_MERGE_W'(do_sel),
                                              DRP_MERGE_W'(wdata_q),
                                              DRP_MERGE_W'(mask_q)));
                  state_d = ST_WR_ISSUE;
               end else begin
                  data_d  = do_sel;
                  state_d = ST_RESP;
               end
            end else if (to_expired) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ch_q      <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         data_q    <= data_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // req_ready is gated with rst_n so that every output is low while reset is held.
   assign req_ready = rst_n && (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign drp_en    = in_issue ? ch_sel : '0;
   assign drp_we    = (state_q == ST_WR_ISSUE) ? ch_sel : '0;
   assign drp_addr  = (in_issue || in_wait) ? addr_q : '0;
   assign drp_di    = (state_q == ST_WR_ISSUE) ? data_q : '0;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_valid ? data_q : '0;
   assign rsp_err   = rsp_valid && err_q;
   assign err_count = err_cnt_q;

endmodule
